// File: rtl/auth_rx.sv
// auth_rx: 8N1 UART receiver feeding a "G"/"S" power-up authorizer.
// pwr_up is decoded straight from the auth state register.
module auth_rx #(
  parameter int BAUD_DIV = 2604
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       RX,
  input  logic       rider_off,
  input  logic       clr_rdy,
  output logic [7:0] rx_data,
  output logic       rdy,
  output logic       pwr_up
);

  localparam logic [11:0] FULL = 12'(BAUD_DIV);
  localparam logic [11:0] HALF = 12'(BAUD_DIV / 2);

  typedef enum logic {
    IDLE,
    RECEIVE
  } rx_state_t;

  typedef enum logic [1:0] {
    OFF,
    PWR1,
    PWR2
  } au_state_t;

  rx_state_t   rx_st, rx_nxt;
  au_state_t   au_st, au_nxt;

  logic        rx_ff1, rx_s;
  logic [11:0] baud_cnt;
  logic [3:0]  bit_cnt;
  logic [7:0]  shreg;
  logic        armed;
  logic        stop_pend;
  logic        rx_vld;

  logic        tick;
  logic        start;
  logic        stop_ok;
  logic        ferr;

  assign tick = (baud_cnt <= 12'd1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_st <= IDLE;
      au_st <= OFF;
    end else begin
      rx_st <= rx_nxt;
      au_st <= au_nxt;
    end
  end

  always_comb begin
    rx_nxt  = rx_st;
    start   = 1'b0;
    stop_ok = 1'b0;
    ferr    = 1'b0;
    unique case (rx_st)
      IDLE: begin
        if (!rx_s && armed) begin
          rx_nxt = RECEIVE;
          start  = 1'b1;
        end
      end
      RECEIVE: begin
        if (tick) begin
          if (bit_cnt == 4'd0 && rx_s) begin
            rx_nxt = IDLE;
          end else if (bit_cnt == 4'd9) begin
            rx_nxt  = IDLE;
            stop_ok = rx_s;
            ferr    = !rx_s;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_ff1    <= 1'b1;
      rx_s      <= 1'b1;
      baud_cnt  <= 12'd0;
      bit_cnt   <= 4'd0;
      shreg     <= 8'hFF;
      rx_data   <= 8'h00;
      rdy       <= 1'b0;
      stop_pend <= 1'b0;
      rx_vld    <= 1'b0;
      armed     <= 1'b1;
    end else begin
      rx_ff1    <= RX;
      rx_s      <= rx_ff1;
      stop_pend <= stop_ok;
      rx_vld    <= stop_pend;
      if (stop_pend) begin
        rx_data <= shreg;
      end
      // a set in the same clk as a clear must win
      if (stop_pend) begin
        rdy <= 1'b1;
      end else if (clr_rdy || start) begin
        rdy <= 1'b0;
      end
      if (ferr) begin
        armed <= 1'b0;
      end else if (rx_s) begin
        armed <= 1'b1;
      end
      if (start) begin
        baud_cnt <= HALF;
        bit_cnt  <= 4'd0;
      end else if (rx_st == RECEIVE) begin
        if (tick) begin
          baud_cnt <= FULL;
          bit_cnt  <= bit_cnt + 4'd1;
          if (bit_cnt != 4'd0 && bit_cnt < 4'd9) begin
            shreg <= {rx_s, shreg[7:1]};
          end
        end else begin
          baud_cnt <= baud_cnt - 12'd1;
        end
      end
    end
  end

  always_comb begin
    au_nxt = au_st;
    unique case (au_st)
      OFF: begin
        if (rx_vld && rx_data == 8'h47) begin
          au_nxt = PWR1;
        end
      end
      PWR1: begin
        if (rx_vld && rx_data == 8'h53) begin
          au_nxt = rider_off ? OFF : PWR2;
        end
      end
      PWR2: begin
        if (rider_off) begin
          au_nxt = OFF;
        end else if (rx_vld && rx_data == 8'h47) begin
          au_nxt = PWR1;
        end
      end
      default: au_nxt = OFF;
    endcase
  end

  assign pwr_up = (au_st != OFF);

endmodule

// File: tb/tb_auth_rx.sv
// tb_auth_rx: directed UART frames against auth_rx.
// Short bit time keeps the run small.
module tb_auth_rx;

  localparam int B   = 16;
  localparam int LIM = 12 * B;

  logic       clk;
  logic       rst_n;
  logic       RX;
  logic       rider_off;
  logic       clr_rdy;
  logic [7:0] rx_data;
  logic       rdy;
  logic       pwr_up;

  int n_chk;
  int n_pass;

  auth_rx #(.BAUD_DIV(B)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .RX       (RX),
    .rider_off(rider_off),
    .clr_rdy  (clr_rdy),
    .rx_data  (rx_data),
    .rdy      (rdy),
    .pwr_up   (pwr_up)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] got,
                     input logic [15:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic send(input logic [7:0] b, input logic stop);
    logic [9:0] f;
    f = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      RX = f[i];
      repeat (B) @(negedge clk);
    end
    RX = 1'b1;
    repeat (B) @(negedge clk);
  endtask

  task automatic wait_rdy(output int n);
    logic lo;
    n  = 0;
    lo = 1'b0;
    while (n < LIM) begin
      @(posedge clk);
      #1;
      n++;
      if (!rdy) lo = 1'b1;
      else if (lo) break;
    end
  endtask

  task automatic send_w(input logic [7:0] b, input logic pb,
                        input logic pa, input string tag,
                        output int n);
    fork
      send(b, 1'b1);
      begin
        wait_rdy(n);
        chk({tag, "_to"}, 16'(n < LIM), 16'd1);
        chk({tag, "_pwr0"}, 16'(pwr_up), 16'(pb));
        @(posedge clk);
        #1;
        chk({tag, "_pwr1"}, 16'(pwr_up), 16'(pa));
      end
    join
    chk({tag, "_data"}, 16'(rx_data), 16'(b));
  endtask

  initial begin
    int n;
    logic [7:0] bb;
    clk       = 1'b0;
    rst_n     = 1'b0;
    RX        = 1'b1;
    rider_off = 1'b0;
    clr_rdy   = 1'b0;
    n_chk     = 0;
    n_pass    = 0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_rdy", 16'(rdy), 16'd0);
    chk("rst_data", 16'(rx_data), 16'h00);
    chk("rst_pwr", 16'(pwr_up), 16'd0);

    send_w(8'h47, 1'b0, 1'b1, "g1", n);
    chk("lat", 16'(n >= (19 * B) / 2 + 2 && n <= (19 * B) / 2 + 4), 16'd1);
    chk("g1_rdy", 16'(rdy), 16'd1);

    send_w(8'h53, 1'b1, 1'b1, "s_ride", n);
    rider_off = 1'b1;
    @(negedge clk);
    chk("pwr2_off", 16'(pwr_up), 16'd0);

    rider_off = 1'b0;
    send_w(8'h47, 1'b0, 1'b1, "g2", n);
    rider_off = 1'b1;
    repeat (3) @(negedge clk);
    chk("pwr1_hold", 16'(pwr_up), 16'd1);
    send_w(8'h53, 1'b1, 1'b0, "s_norider", n);

    RX = 1'b0;
    repeat (1000) @(negedge clk);
    RX = 1'b1;
    repeat (3 * B) @(negedge clk);
    chk("brk_rdy", 16'(rdy), 16'd0);
    chk("brk_data", 16'(rx_data), 16'h53);
    chk("brk_pwr", 16'(pwr_up), 16'd0);

    rider_off = 1'b0;
    send_w(8'h47, 1'b0, 1'b1, "g3", n);
    rider_off = 1'b1;
    send(8'h53, 1'b0);
    chk("ferr_rdy", 16'(rdy), 16'd0);
    chk("ferr_data", 16'(rx_data), 16'h47);
    chk("ferr_pwr", 16'(pwr_up), 16'd1);
    rider_off = 1'b0;

    send_w(8'hA5, 1'b1, 1'b1, "a5", n);
    repeat (20) @(negedge clk);
    chk("a5_rdy", 16'(rdy), 16'd1);
    clr_rdy = 1'b1;
    @(negedge clk);
    clr_rdy = 1'b0;
    chk("clr_rdy", 16'(rdy), 16'd0);
    chk("clr_pwr", 16'(pwr_up), 16'd1);
    chk("clr_data", 16'(rx_data), 16'hA5);

    RX = 1'b0;
    repeat (3) @(negedge clk);
    RX = 1'b1;
    repeat (2 * B) @(negedge clk);
    chk("glitch_rdy", 16'(rdy), 16'd0);
    chk("glitch_data", 16'(rx_data), 16'hA5);
    send_w(8'h53, 1'b1, 1'b1, "s_after", n);
    send_w(8'h47, 1'b1, 1'b1, "g_pwr2", n);
    rider_off = 1'b1;
    repeat (2) @(negedge clk);
    chk("pwr2_to_pwr1", 16'(pwr_up), 16'd1);
    rider_off = 1'b0;

    clr_rdy = 1'b1;
    send_w(8'h00, 1'b1, 1'b1, "set_wins", n);
    chk("set_wins_clr", 16'(rdy), 16'd0);
    clr_rdy = 1'b0;

    bb = 8'h47;
    RX = 1'b0;
    repeat (B) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      RX = bb[i];
      repeat (B) @(negedge clk);
    end
    RX = bb[4];
    repeat (B / 2) @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    RX = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3 * B) @(negedge clk);
    chk("mid_rdy", 16'(rdy), 16'd0);
    chk("mid_data", 16'(rx_data), 16'h00);
    chk("mid_pwr", 16'(pwr_up), 16'd0);
    send_w(8'h47, 1'b0, 1'b1, "g_fresh", n);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
